// File: rtl/i2c_apb_regs.sv
// APB register front end for an I2C controller: CTRL/ADDR registers, a TX FIFO
// feeding the controller's data_in, and an RX FIFO drained through RXDATA reads.
module i2c_apb_regs #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  // APB slave
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [2:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  // toward the I2C controller
  output logic       enable,
  output logic [6:0] slave_address,
  output logic       rw,
  output logic       repeated_start_cond,
  output logic [7:0] data_in,
  // controller handshake
  input  logic       tx_pop,
  input  logic       rx_push,
  input  logic [7:0] rx_data
);

  // Handshake: an APB access completes at the rising edge where PSEL & PENABLE
  // are high; PREADY is tied high so every access is zero-wait. tx_pop/rx_push
  // are single-cycle strobes sampled at the rising edge, with no back-pressure.

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RCW = RAW + 1;
  localparam logic [TAW:0] TX_FULL_CNT = TX_DEPTH[TAW:0];
  localparam logic [RAW:0] RX_FULL_CNT = RX_DEPTH[RAW:0];

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_ADDR   = 3'd1;
  localparam logic [2:0] A_TXDATA = 3'd2;
  localparam logic [2:0] A_RXDATA = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;
  localparam logic [2:0] A_TXCNT  = 3'd5;
  localparam logic [2:0] A_RXCNT  = 3'd6;

  logic       apb_wr, apb_rd;
  logic       ctrl_en, ctrl_rw, ctrl_rep;
  logic [6:0] addr_reg;
  logic       tx_ovf, rx_ovf;
  logic       status_wr;
  logic [7:0] status;

  assign apb_wr    = PSEL & PENABLE & PWRITE;
  assign apb_rd    = PSEL & PENABLE & ~PWRITE;
  assign status_wr = apb_wr & (PADDR == A_STATUS);

  // ---------------- TX FIFO ----------------
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_rd_ptr, tx_wr_ptr;
  logic [TAW:0]   tx_cnt;
  logic           tx_empty, tx_full;
  logic           tx_push_req, tx_do_push, tx_do_pop, tx_ovf_set;

  assign tx_empty    = (tx_cnt == '0);
  assign tx_full     = (tx_cnt == TX_FULL_CNT);
  assign tx_push_req = apb_wr & (PADDR == A_TXDATA);
  assign tx_do_pop   = tx_pop & ~tx_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign tx_do_push  = tx_push_req & (~tx_full | tx_do_pop);
  assign tx_ovf_set  = tx_push_req & tx_full & ~tx_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_cnt    <= '0;
    end else begin
      if (tx_do_push) tx_wr_ptr <= tx_wr_ptr + TAW'(1);
      if (tx_do_pop)  tx_rd_ptr <= tx_rd_ptr + TAW'(1);
      case ({tx_do_push, tx_do_pop})
        2'b10:   tx_cnt <= tx_cnt + TCW'(1);
        2'b01:   tx_cnt <= tx_cnt - TCW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_do_push) tx_mem[tx_wr_ptr] <= PWDATA;
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_rd_ptr, rx_wr_ptr;
  logic [RAW:0]   rx_cnt;
  logic           rx_empty, rx_full;
  logic           rx_pop_req, rx_do_push, rx_do_pop, rx_ovf_set;
  logic [7:0]     rx_head;

  assign rx_empty   = (rx_cnt == '0);
  assign rx_full    = (rx_cnt == RX_FULL_CNT);
  assign rx_pop_req = apb_rd & (PADDR == A_RXDATA);
  assign rx_do_pop  = rx_pop_req & ~rx_empty;
  assign rx_do_push = rx_push & (~rx_full | rx_do_pop);
  assign rx_ovf_set = rx_push & rx_full & ~rx_pop_req;
  assign rx_head    = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_cnt    <= '0;
    end else begin
      if (rx_do_push) rx_wr_ptr <= rx_wr_ptr + RAW'(1);
      if (rx_do_pop)  rx_rd_ptr <= rx_rd_ptr + RAW'(1);
      case ({rx_do_push, rx_do_pop})
        2'b10:   rx_cnt <= rx_cnt + RCW'(1);
        2'b01:   rx_cnt <= rx_cnt - RCW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_do_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  // ---------------- control registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en  <= 1'b0;
      ctrl_rw  <= 1'b0;
      ctrl_rep <= 1'b0;
      addr_reg <= '0;
      tx_ovf   <= 1'b0;
      rx_ovf   <= 1'b0;
    end else begin
      if (apb_wr && PADDR == A_CTRL) begin
        ctrl_en  <= PWDATA[0];
        ctrl_rw  <= PWDATA[1];
        ctrl_rep <= PWDATA[2];
      end
      if (apb_wr && PADDR == A_ADDR) addr_reg <= PWDATA[6:0];
      // Set wins over a same-cycle write-1-to-clear.
      tx_ovf <= tx_ovf_set | (tx_ovf & ~(status_wr & PWDATA[4]));
      rx_ovf <= rx_ovf_set | (rx_ovf & ~(status_wr & PWDATA[5]));
    end
  end

  assign status = {2'b00, rx_ovf, tx_ovf, rx_full, rx_empty, tx_full, tx_empty};

  always_comb begin
    PRDATA = 8'h00;
    if (apb_rd) begin
      case (PADDR)
        A_CTRL:   PRDATA = {5'b0, ctrl_rep, ctrl_rw, ctrl_en};
        A_ADDR:   PRDATA = {1'b0, addr_reg};
        A_RXDATA: PRDATA = rx_head;
        A_STATUS: PRDATA = status;
        A_TXCNT:  PRDATA = 8'(tx_cnt);
        A_RXCNT:  PRDATA = 8'(rx_cnt);
        default:  PRDATA = 8'h00;
      endcase
    end
  end

  assign PREADY              = 1'b1;
  assign PSLVERR             = 1'b0;
  assign slave_address       = addr_reg;
  assign rw                  = ctrl_rw;
  assign repeated_start_cond = ctrl_rep;
  assign data_in             = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];
  // A write transfer must not run with nothing to send.
  assign enable              = ctrl_en & (~ctrl_rw | ~tx_empty);

endmodule

// File: tb/tb_i2c_apb_regs.sv
// Directed bench for i2c_apb_regs: APB register access, TX/RX FIFO ordering,
// overflow flags, and asynchronous reset behaviour.
module tb_i2c_apb_regs;

  logic       clk = 1'b0;
  logic       rst;
  logic       PSEL, PENABLE, PWRITE;
  logic [2:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY, PSLVERR;
  logic       enable;
  logic [6:0] slave_address;
  logic       rw, repeated_start_cond;
  logic [7:0] data_in;
  logic       tx_pop, rx_push;
  logic [7:0] rx_data;

  int errors = 0;
  int checks = 0;
  logic [7:0] rd;
  logic [7:0] exp_q[$];

  i2c_apb_regs #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .enable(enable), .slave_address(slave_address), .rw(rw),
    .repeated_start_cond(repeated_start_cond), .data_in(data_in),
    .tx_pop(tx_pop), .rx_push(rx_push), .rx_data(rx_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Write with optional side strobes landing on the same completing edge.
  task automatic apb_write_side(input logic [2:0] a, input logic [7:0] d,
                                input logic pop_tx, input logic push_rx,
                                input logic [7:0] rx_byte);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(negedge clk);
    PENABLE = 1'b1; tx_pop = pop_tx; rx_push = push_rx; rx_data = rx_byte;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; tx_pop = 1'b0; rx_push = 1'b0;
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [7:0] d);
    apb_write_side(a, d, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic apb_setup_only(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(negedge clk);
    PSEL = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(negedge clk);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic pulse_tx_pop();
    @(negedge clk); tx_pop = 1'b1;
    @(negedge clk); tx_pop = 1'b0;
  endtask

  task automatic pulse_rx_push(input logic [7:0] d);
    @(negedge clk); rx_push = 1'b1; rx_data = d;
    @(negedge clk); rx_push = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    tx_pop = 0; rx_push = 0; rx_data = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_enable", enable, 8'h00);
    check_eq("rst_saddr", slave_address, 8'h00);
    check_eq("rst_data_in", data_in, 8'h00);
    check_eq("rst_pready", PREADY, 8'h01);
    check_eq("rst_pslverr", PSLVERR, 8'h00);
    rst = 1'b0;
    apb_read(3'd4, rd); check_eq("status_after_rst", rd, 8'h05);

    // setup phase alone must not write
    apb_setup_only(3'd1, 8'h55);
    apb_read(3'd1, rd); check_eq("setup_only_addr", rd, 8'h00);

    // basic write transfer setup; ADDR bit7 is not stored
    apb_write(3'd1, 8'hEB);
    apb_write(3'd0, 8'h03);
    check_eq("enable_rw_empty", enable, 8'h00);
    apb_write(3'd2, 8'hAA);
    check_eq("saddr", slave_address, 8'h6B);
    check_eq("rw", rw, 8'h01);
    check_eq("data_in_aa", data_in, 8'hAA);
    check_eq("enable_with_data", enable, 8'h01);
    apb_read(3'd0, rd); check_eq("ctrl_rd", rd, 8'h03);
    apb_read(3'd1, rd); check_eq("addr_rd", rd, 8'h6B);
    apb_read(3'd2, rd); check_eq("txdata_rd", rd, 8'h00);
    apb_read(3'd5, rd); check_eq("txcnt_1", rd, 8'h01);
    pulse_tx_pop();
    check_eq("data_in_drained", data_in, 8'h00);
    check_eq("enable_drained", enable, 8'h00);
    pulse_tx_pop();  // pop on empty: no effect, no flag
    apb_read(3'd5, rd); check_eq("txcnt_empty_pop", rd, 8'h00);
    apb_read(3'd4, rd); check_eq("status_empty_pop", rd, 8'h05);

    // TX overflow: fifth byte dropped
    for (int i = 1; i <= 5; i++) apb_write(3'd2, 8'(i));
    apb_read(3'd5, rd); check_eq("txcnt_full", rd, 8'h04);
    apb_read(3'd4, rd); check_eq("status_tx_ovf", rd, 8'h16);
    for (int i = 1; i <= 4; i++) begin
      check_eq("tx_order", data_in, 8'(i));
      pulse_tx_pop();
    end
    check_eq("data_in_after_4", data_in, 8'h00);
    check_eq("enable_after_4", enable, 8'h00);
    apb_write(3'd4, 8'h10);
    apb_read(3'd4, rd); check_eq("status_tx_ovf_clr", rd, 8'h05);

    // read direction enables without data; repeated start
    apb_write(3'd0, 8'h05);
    check_eq("enable_read_dir", enable, 8'h01);
    check_eq("rep_start", repeated_start_cond, 8'h01);
    check_eq("rw_read_dir", rw, 8'h00);
    apb_write(3'd0, 8'h03);

    // full TX with push and pop on the same edge
    exp_q.delete();
    for (int i = 1; i <= 4; i++) apb_write(3'd2, 8'(i * 16));
    apb_write_side(3'd2, 8'h50, 1'b1, 1'b0, 8'h00);
    exp_q = '{8'h20, 8'h30, 8'h40, 8'h50};
    apb_read(3'd5, rd); check_eq("txcnt_push_pop", rd, 8'h04);
    apb_read(3'd4, rd); check_eq("status_push_pop", rd, 8'h06);
    while (exp_q.size() > 0) begin
      check_eq("tx_pp_order", data_in, exp_q.pop_front());
      pulse_tx_pop();
    end

    // RX path
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h00};
    pulse_rx_push(8'h11); pulse_rx_push(8'h22); pulse_rx_push(8'h33);
    apb_read(3'd6, rd); check_eq("rxcnt_3", rd, 8'h03);
    while (exp_q.size() > 0) begin
      apb_read(3'd3, rd); check_eq("rx_order", rd, exp_q.pop_front());
    end
    apb_read(3'd6, rd); check_eq("rxcnt_0", rd, 8'h00);
    apb_read(3'd4, rd); check_eq("status_rx_empty", rd, 8'h05);

    // overflow set beats same-cycle clear
    for (int i = 0; i < 5; i++) pulse_rx_push(8'hA0 + 8'(i));
    for (int i = 1; i <= 5; i++) apb_write(3'd2, 8'h60 + 8'(i));
    apb_read(3'd4, rd); check_eq("status_both_ovf", rd, 8'h3A);
    apb_write_side(3'd4, 8'h30, 1'b0, 1'b1, 8'hBB);
    apb_read(3'd4, rd); check_eq("status_set_wins", rd, 8'h2A);
    apb_write(3'd4, 8'h30);
    apb_read(3'd4, rd); check_eq("status_both_clr", rd, 8'h0A);
    apb_read(3'd3, rd); check_eq("rx_head_kept", rd, 8'hA0);
    apb_read(3'd6, rd); check_eq("rxcnt_after_pop", rd, 8'h03);

    // asynchronous reset between edges with two bytes queued
    pulse_tx_pop(); pulse_tx_pop();
    check_eq("pre_rst_data_in", data_in, 8'h63);
    check_eq("pre_rst_enable", enable, 8'h01);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_enable", enable, 8'h00);
    check_eq("arst_rw", rw, 8'h00);
    check_eq("arst_rep", repeated_start_cond, 8'h00);
    check_eq("arst_saddr", slave_address, 8'h00);
    check_eq("arst_data_in", data_in, 8'h00);
    check_eq("arst_prdata", PRDATA, 8'h00);
    check_eq("arst_pready", PREADY, 8'h01);
    check_eq("arst_pslverr", PSLVERR, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    apb_read(3'd5, rd); check_eq("txcnt_after_rst", rd, 8'h00);
    apb_read(3'd6, rd); check_eq("rxcnt_after_rst", rd, 8'h00);
    apb_read(3'd4, rd); check_eq("status_after_arst", rd, 8'h05);
    apb_read(3'd0, rd); check_eq("ctrl_after_arst", rd, 8'h00);
    apb_read(3'd7, rd); check_eq("reg7_rd", rd, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
